// File: rtl/song_pkg.sv
// Shared playback types and song-length defaults, so the note ROMs and the sequencer agree.
// Pure declarations: no timing, no flow control.
package song_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAYING,
        ST_PAUSED,
        ST_DONE
    } state_t;

    localparam logic [1:0] TEMPO_NORMAL     = 2'b00;
    localparam logic [1:0] TEMPO_DOUBLE     = 2'b01;
    localparam logic [1:0] TEMPO_HALF       = 2'b10;
    localparam logic [1:0] TEMPO_NORMAL_ALT = 2'b11;

    localparam int SONG1_LEN_DEFAULT = 365;
    localparam int SONG2_LEN_DEFAULT = 261;

endpackage

// File: rtl/song_sequencer_step_timer.sv
// Programmable step divider: counts 0..period-1 while run is high, freezes otherwise.
// tc_o is combinational and asserts on the last count of a running period.
module step_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = run_i && (cnt_q == period_i - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song playback controller: steps the shared ROM address at the latched tempo and forwards the selected note.
// note_out trails a rom_addr change by two cycles; play/pause/stop are single-cycle pulses, stop has priority.
module song_sequencer
    import song_pkg::*;
#(
    parameter int TICK_DIV  = 6_250_000,
    parameter int SONG1_LEN = SONG1_LEN_DEFAULT,
    parameter int SONG2_LEN = SONG2_LEN_DEFAULT,
    parameter int ADDR_W    = 10,
    parameter int NOTE_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              song_sel,
    input  logic [1:0]        tempo_sel,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom1_note,
    input  logic [NOTE_W-1:0] rom2_note,
    output logic [NOTE_W-1:0] note_out,
    output logic              playing,
    output logic              done
);

    localparam int CNT_W = $clog2(2 * TICK_DIV + 1);

    state_t            state_q;
    logic              song_q;
    logic [CNT_W-1:0]  period_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NOTE_W-1:0] note_q;
    logic              playing_q;
    logic              done_q;
    logic              first_q;

    logic              start;
    logic              run;
    logic              tc;
    logic [ADDR_W-1:0] last_addr;
    logic [CNT_W-1:0]  period_d;

    assign start     = play && !stop && (state_q == ST_IDLE || state_q == ST_DONE);
    assign run       = (state_q == ST_PLAYING) && !pause && !stop;
    assign last_addr = song_q ? ADDR_W'(SONG2_LEN - 1) : ADDR_W'(SONG1_LEN - 1);

    always_comb begin
        period_d = CNT_W'(TICK_DIV);
        case (tempo_sel)
            TEMPO_DOUBLE: period_d = CNT_W'(TICK_DIV / 2);
            TEMPO_HALF:   period_d = CNT_W'(2 * TICK_DIV);
            default:      period_d = CNT_W'(TICK_DIV);
        endcase
    end

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .run_i    (run),
        .clr_i    (stop || start),
        .period_i (period_q),
        .tc_o     (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            song_q    <= 1'b0;
            period_q  <= CNT_W'(TICK_DIV);
            addr_q    <= '0;
            note_q    <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            first_q <= 1'b0;
            // The ROM still holds the previous address's note during the first PLAYING cycle.
            note_q  <= (state_q == ST_PLAYING && !first_q) ? (song_q ? rom2_note : rom1_note) : '0;
            if (stop) begin
                state_q   <= ST_IDLE;
                addr_q    <= '0;
                playing_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (play) begin
                            song_q    <= song_sel;
                            period_q  <= period_d;
                            addr_q    <= '0;
                            state_q   <= ST_PLAYING;
                            playing_q <= 1'b1;
                            first_q   <= 1'b1;
                        end
                    end
                    ST_PLAYING: begin
                        if (pause) begin
                            state_q   <= ST_PAUSED;
                            playing_q <= 1'b0;
                        end else if (tc) begin
                            if (addr_q < last_addr) begin
                                addr_q <= addr_q + ADDR_W'(1);
                            end else if (loop_en) begin
                                addr_q <= '0;
                            end else begin
                                state_q   <= ST_DONE;
                                playing_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (play) begin
                            state_q   <= ST_PLAYING;
                            playing_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rom_addr = addr_q;
    assign note_out = note_q;
    assign playing  = playing_q;
    assign done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_DIV=4, SONG1_LEN=6, SONG2_LEN=3.
// ROM model: registered read returning 10+addr (song 1) and 20+addr (song 2).
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       play;
    logic       pause;
    logic       stop;
    logic       song_sel;
    logic [1:0] tempo_sel;
    logic       loop_en;
    logic [9:0] rom_addr;
    logic [9:0] rom1_note;
    logic [9:0] rom2_note;
    logic [9:0] note_out;
    logic       playing;
    logic       done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       play;
        logic [9:0] exp_addr;
        logic [9:0] exp_note;
        logic       exp_playing;
        logic       exp_done;
    } vec_t;

    vec_t       tbl [27];
    logic [9:0] ea;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom1_note <= 10'd10 + rom_addr;
        rom2_note <= 10'd20 + rom_addr;
    end

    song_sequencer #(
        .TICK_DIV  (4),
        .SONG1_LEN (6),
        .SONG2_LEN (3),
        .ADDR_W    (10),
        .NOTE_W    (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .play      (play),
        .pause     (pause),
        .stop      (stop),
        .song_sel  (song_sel),
        .tempo_sel (tempo_sel),
        .loop_en   (loop_en),
        .rom_addr  (rom_addr),
        .rom1_note (rom1_note),
        .rom2_note (rom2_note),
        .note_out  (note_out),
        .playing   (playing),
        .done      (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_addr"}, 32'(rom_addr), 0);
        chk({name, "_playing"}, 32'(playing), 0);
        chk({name, "_done"}, 32'(done), 0);
    endtask

    initial begin
        rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0;
        song_sel = 1'b0; tempo_sel = 2'b00; loop_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_note", 32'(note_out), 0);

        // Song 1, normal tempo: address t/4, note two cycles behind, done after address 5.
        for (int t = 0; t < 27; t++) begin
            tbl[t].play        = (t == 0);
            tbl[t].exp_addr    = (t < 24) ? 10'(t / 4) : 10'd5;
            tbl[t].exp_note    = (t >= 2 && t <= 24) ? 10'(10 + (t - 2) / 4) : 10'd0;
            tbl[t].exp_playing = (t < 24);
            tbl[t].exp_done    = (t == 24);
        end

        pause = 1'b1;
        step();
        pause = 1'b0;
        chk_idle("pause_in_idle");

        for (int i = 0; i < 27; i++) begin
            play = tbl[i].play;
            step();
            play = 1'b0;
            chk($sformatf("s1_addr[%0d]", i), 32'(rom_addr), 32'(tbl[i].exp_addr));
            chk($sformatf("s1_note[%0d]", i), 32'(note_out), 32'(tbl[i].exp_note));
            chk($sformatf("s1_playing[%0d]", i), 32'(playing), 32'(tbl[i].exp_playing));
            chk($sformatf("s1_done[%0d]", i), 32'(done), 32'(tbl[i].exp_done));
        end

        // Song 2 looping from DONE, then loop_en dropped after two full passes.
        song_sel = 1'b1;
        loop_en  = 1'b1;
        play     = 1'b1;
        step();
        play = 1'b0;
        for (int t = 0; t <= 37; t++) begin
            if (t > 0) step();
            if (t <= 24)      ea = 10'((t / 4) % 3);
            else if (t < 28)  ea = 10'd0;
            else if (t < 32)  ea = 10'd1;
            else              ea = 10'd2;
            chk($sformatf("s2_addr[%0d]", t), 32'(rom_addr), 32'(ea));
            chk($sformatf("s2_done[%0d]", t), 32'(done), 32'(t == 36));
            chk($sformatf("s2_playing[%0d]", t), 32'(playing), 32'(t < 36));
            if (t == 1)  chk("s2_note_first_gap", 32'(note_out), 0);
            if (t == 2)  chk("s2_note_a0", 32'(note_out), 20);
            if (t == 6)  chk("s2_note_a1", 32'(note_out), 21);
            if (t == 10) chk("s2_note_a2", 32'(note_out), 22);
            if (t == 37) chk("s2_note_after_done", 32'(note_out), 0);
            if (t == 24) loop_en = 1'b0;
        end

        // Pause with two counts of address 3 remaining.
        song_sel = 1'b0;
        play     = 1'b1;
        step();
        play = 1'b0;
        repeat (14) step();
        chk("p_pre_addr", 32'(rom_addr), 3);
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("p_addr", 32'(rom_addr), 3);
        chk("p_playing", 32'(playing), 0);
        step();
        chk("p_note", 32'(note_out), 0);
        repeat (9) step();
        chk("p_hold_addr", 32'(rom_addr), 3);
        chk("p_hold_note", 32'(note_out), 0);
        play = 1'b1;
        step();
        play = 1'b0;
        chk("p_resume_playing", 32'(playing), 1);
        chk("p_resume_addr0", 32'(rom_addr), 3);
        step();
        chk("p_resume_addr1", 32'(rom_addr), 3);
        step();
        chk("p_resume_addr2", 32'(rom_addr), 4);
        chk("p_resume_note", 32'(note_out), 13);

        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("stop_mid");
        step();
        chk("stop_mid_note", 32'(note_out), 0);
        chk_idle("stop_mid_next");

        // Pause coinciding with the terminal count of address 3.
        play = 1'b1;
        step();
        play = 1'b0;
        repeat (15) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("ptc_addr", 32'(rom_addr), 3);
        chk("ptc_playing", 32'(playing), 0);
        repeat (10) step();
        chk("ptc_hold_addr", 32'(rom_addr), 3);
        chk("ptc_hold_note", 32'(note_out), 0);
        play = 1'b1;
        step();
        play = 1'b0;
        chk("ptc_resume_addr0", 32'(rom_addr), 3);
        chk("ptc_resume_playing", 32'(playing), 1);
        step();
        chk("ptc_resume_addr1", 32'(rom_addr), 4);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Double speed: two cycles per address.
        tempo_sel = 2'b01;
        play      = 1'b1;
        step();
        play = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            step();
            if (t == 1) chk("dbl_addr_t1", 32'(rom_addr), 0);
            if (t == 2) chk("dbl_addr_t2", 32'(rom_addr), 1);
            if (t == 4) chk("dbl_addr_t4", 32'(rom_addr), 2);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Half speed; tempo_sel/song_sel changes mid-song must not take effect.
        tempo_sel = 2'b10;
        song_sel  = 1'b0;
        play      = 1'b1;
        step();
        play = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            step();
            if (t == 7)  chk("half_addr_t7", 32'(rom_addr), 0);
            if (t == 8)  chk("half_addr_t8", 32'(rom_addr), 1);
            if (t == 15) chk("half_addr_t15", 32'(rom_addr), 1);
            if (t == 16) chk("half_addr_t16", 32'(rom_addr), 2);
            if (t == 18) chk("half_note_t18", 32'(note_out), 12);
            if (t == 8) begin
                tempo_sel = 2'b01;
                song_sel  = 1'b1;
            end
        end

        // stop wins over a simultaneous play.
        stop = 1'b1;
        play = 1'b1;
        step();
        stop = 1'b0;
        play = 1'b0;
        chk_idle("stop_play");
        step();
        chk("stop_play_note", 32'(note_out), 0);
        repeat (5) step();
        chk_idle("stop_play_later");

        // Reset while paused.
        tempo_sel = 2'b00;
        song_sel  = 1'b0;
        play      = 1'b1;
        step();
        play = 1'b0;
        repeat (5) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("rp_addr", 32'(rom_addr), 1);
        chk("rp_playing", 32'(playing), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rp_reset");
        chk("rp_reset_note", 32'(note_out), 0);
        step();
        chk_idle("rp_after");
        chk("rp_after_note", 32'(note_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
